// File: rtl/dataslot_cmd_initiator_if.sv
// Request/response and bridge target-command signals of dataslot_cmd_initiator.
// master = the initiator itself, slave = core clients plus the bridge handler.
interface dataslot_cmd_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_id;
    logic [31:0] req_slotoffset;
    logic [31:0] req_bridgeaddr;
    logic [31:0] req_length;

    logic        rsp_valid;
    logic [2:0]  rsp_err;
    logic        rsp_timeout;
    logic        busy;

    logic        target_dataslot_read;
    logic        target_dataslot_write;
    logic        target_dataslot_ack;
    logic        target_dataslot_done;
    logic [2:0]  target_dataslot_err;
    logic [15:0] target_dataslot_id;
    logic [31:0] target_dataslot_slotoffset;
    logic [31:0] target_dataslot_bridgeaddr;
    logic [31:0] target_dataslot_length;

    modport master (
        input  req_valid, req_write, req_id, req_slotoffset,
        input  req_bridgeaddr, req_length,
        input  target_dataslot_ack, target_dataslot_done,
        input  target_dataslot_err,
        output req_ready, rsp_valid, rsp_err, rsp_timeout, busy,
        output target_dataslot_read, target_dataslot_write,
        output target_dataslot_id, target_dataslot_slotoffset,
        output target_dataslot_bridgeaddr, target_dataslot_length
    );

    modport slave (
        output req_valid, req_write, req_id, req_slotoffset,
        output req_bridgeaddr, req_length,
        output target_dataslot_ack, target_dataslot_done,
        output target_dataslot_err,
        input  req_ready, rsp_valid, rsp_err, rsp_timeout, busy,
        input  target_dataslot_read, target_dataslot_write,
        input  target_dataslot_id, target_dataslot_slotoffset,
        input  target_dataslot_bridgeaddr, target_dataslot_length
    );
endinterface

// File: rtl/dataslot_cmd_initiator.sv
// Issues one dataslot read/write target command at a time and reports completion.
// Optional timeout compiled in with `define DATASLOT_CMD_TIMEOUT_EN.
module dataslot_cmd_initiator #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd74_250_000,
    parameter int unsigned GAP_CYCLES     = 4
) (
    input logic                       clk_74a,
    input logic                       reset_n,
    dataslot_cmd_initiator_if.master  bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STROBE    = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

    localparam logic [4:0] GAP_W = 5'(GAP_CYCLES);

    state_t      state_q;
    logic        rd_q;
    logic        wr_q;
    logic        rsp_valid_q;
    logic        rsp_timeout_q;
    logic [2:0]  rsp_err_q;
    logic [15:0] id_q;
    logic [31:0] off_q;
    logic [31:0] addr_q;
    logic [31:0] len_q;
    logic [3:0]  gap_q;
    logic        gap_done;
    logic        tmo_hit;

    // gap_q counts GAP cycles already spent; exit once this one completes the gap
    assign gap_done = (({1'b0, gap_q} + 5'd1) >= GAP_W);

`ifdef DATASLOT_CMD_TIMEOUT_EN
    logic [31:0] tmo_q;

    // >= so a timeout deadline passed while ack won stays pending in WAIT_DONE
    assign tmo_hit = ({1'b0, tmo_q} + 33'd1) >= {1'b0, TIMEOUT_CYCLES};

    // Command age: cleared while idle, counts while the command is outstanding
    always_ff @(posedge clk_74a) begin
        if (!reset_n) begin
            tmo_q <= 32'd0;
        end else if (state_q == STROBE || state_q == WAIT_DONE) begin
            tmo_q <= tmo_q + 32'd1;
        end else begin
            tmo_q <= 32'd0;
        end
    end
`else
    wire unused_tmo = ^TIMEOUT_CYCLES;

    assign tmo_hit = 1'b0;
`endif

    // Command FSM with registered strobes, parameters and completion
    always_ff @(posedge clk_74a) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            rd_q          <= 1'b0;
            wr_q          <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_err_q     <= 3'd0;
            id_q          <= 16'd0;
            off_q         <= 32'd0;
            addr_q        <= 32'd0;
            len_q         <= 32'd0;
            gap_q         <= 4'd0;
        end else begin
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        state_q <= STROBE;
                        rd_q    <= ~bus.req_write;
                        wr_q    <= bus.req_write;
                        id_q    <= bus.req_id;
                        off_q   <= bus.req_slotoffset;
                        addr_q  <= bus.req_bridgeaddr;
                        len_q   <= bus.req_length;
                    end
                end
                STROBE: begin
                    if (bus.target_dataslot_ack) begin
                        state_q <= WAIT_DONE;
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                    end else if (tmo_hit) begin
                        state_q       <= GAP;
                        rd_q          <= 1'b0;
                        wr_q          <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_err_q     <= 3'b111;
                        gap_q         <= 4'd0;
                    end
                end
                WAIT_DONE: begin
                    if (bus.target_dataslot_done) begin
                        state_q     <= GAP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= bus.target_dataslot_err;
                        gap_q       <= 4'd0;
                    end else if (tmo_hit) begin
                        state_q       <= GAP;
                        rsp_valid_q   <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_err_q     <= 3'b111;
                        gap_q         <= 4'd0;
                    end
                end
                GAP: begin
                    if (gap_done && !bus.target_dataslot_ack) begin
                        state_q <= IDLE;
                    end else if (!gap_done) begin
                        gap_q <= gap_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready                  = (state_q == IDLE);
    assign bus.busy                       = (state_q != IDLE);
    assign bus.rsp_valid                  = rsp_valid_q;
    assign bus.rsp_err                    = rsp_err_q;
    assign bus.rsp_timeout                = rsp_timeout_q;
    assign bus.target_dataslot_read       = rd_q;
    assign bus.target_dataslot_write      = wr_q;
    assign bus.target_dataslot_id         = id_q;
    assign bus.target_dataslot_slotoffset = off_q;
    assign bus.target_dataslot_bridgeaddr = addr_q;
    assign bus.target_dataslot_length     = len_q;
endmodule

// File: tb/tb_dataslot_cmd_initiator.sv
// Directed bench for dataslot_cmd_initiator: vector table plus corner sequences.
// Inputs change and outputs are sampled on the falling edge of clk_74a.
module tb_dataslot_cmd_initiator;
    localparam int GAP = 4;
    localparam int TMO = 100;

    logic clk = 1'b0;
    logic reset_n;
    int   errs = 0;
    int   checks = 0;

    dataslot_cmd_initiator_if bus ();

    dataslot_cmd_initiator #(
        .TIMEOUT_CYCLES(32'(TMO)),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk_74a(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [15:0] id;
        logic [31:0] off;
        logic [31:0] addr;
        logic [31:0] len;
        int          ack_dly;
        int          done_dly;
        logic [2:0]  err;
        logic [2:0]  exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_params(input string name, input vec_t v);
        chk({name, "_id"}, {16'd0, bus.target_dataslot_id}, {16'd0, v.id});
        chk({name, "_off"}, bus.target_dataslot_slotoffset, v.off);
        chk({name, "_addr"}, bus.target_dataslot_bridgeaddr, v.addr);
        chk({name, "_len"}, bus.target_dataslot_length, v.len);
    endtask

    // Waits for req_ready and checks how many cycles after the rsp pulse it took
    task automatic wait_ready(input string name, input int exp_n);
        int n;
        n = 0;
        while (!bus.req_ready && n < 300) begin
            @(negedge clk);
            n++;
            if (n == 1) chk({name, "_rsp_one_cycle"}, bus.rsp_valid, 0);
        end
        if (exp_n >= 0) chk({name, "_gap_len"}, n, exp_n);
        else chk({name, "_ready_timeout"}, bus.req_ready, 1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string nm;
        nm = $sformatf("vec%0d", idx);
        chk({nm, "_ready"}, bus.req_ready, 1);
        bus.req_valid      = 1'b1;
        bus.req_write      = v.wr;
        bus.req_id         = v.id;
        bus.req_slotoffset = v.off;
        bus.req_bridgeaddr = v.addr;
        bus.req_length     = v.len;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk({nm, "_rd"}, bus.target_dataslot_read, !v.wr);
        chk({nm, "_wr"}, bus.target_dataslot_write, v.wr);
        chk({nm, "_busy"}, bus.busy, 1);
        chk({nm, "_ready_low"}, bus.req_ready, 0);
        chk_params(nm, v);
        for (int k = 0; k < v.ack_dly; k++) begin
            @(negedge clk);
            chk({nm, "_strobe_hold"},
                {bus.target_dataslot_write, bus.target_dataslot_read},
                v.wr ? 2'b10 : 2'b01);
        end
        bus.target_dataslot_ack = 1'b1;
        @(negedge clk);
        bus.target_dataslot_ack = 1'b0;
        chk({nm, "_strobe_drop"},
            {bus.target_dataslot_write, bus.target_dataslot_read}, 0);
        for (int k = 0; k < v.done_dly; k++) begin
            @(negedge clk);
            chk({nm, "_wait_quiet"},
                {bus.rsp_valid, bus.target_dataslot_write,
                 bus.target_dataslot_read}, 0);
        end
        bus.target_dataslot_done = 1'b1;
        bus.target_dataslot_err  = v.err;
        @(negedge clk);
        bus.target_dataslot_done = 1'b0;
        bus.target_dataslot_err  = 3'd0;
        chk({nm, "_rsp_valid"}, bus.rsp_valid, 1);
        chk({nm, "_rsp_err"}, bus.rsp_err, v.exp_err);
        chk({nm, "_rsp_tmo"}, bus.rsp_timeout, 0);
        wait_ready(nm, GAP);
        chk_params({nm, "_hold"}, v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int   first;
        int   second;
        int   nrsp;
        int   nrdy;
        int   n;
        logic s;
        logic s_prev;

        vecs[0] = '{1'b0, 16'd3, 32'h10, 32'h2000_0000, 32'h200,
                    2, 5, 3'b000, 3'b000};
        vecs[1] = '{1'b1, 16'd7, 32'h40, 32'h3000_0000, 32'h80,
                    0, 0, 3'b010, 3'b010};
        vecs[2] = '{1'b0, 16'hffff, 32'hffff_ffff, 32'h0, 32'h1,
                    1, 3, 3'b101, 3'b101};
        vecs[3] = '{1'b1, 16'h1234, 32'h0, 32'hdead_beef, 32'hffff_ffff,
                    4, 2, 3'b111, 3'b111};

        reset_n                  = 1'b0;
        bus.req_valid            = 1'b0;
        bus.req_write            = 1'b0;
        bus.req_id               = 16'd0;
        bus.req_slotoffset       = 32'd0;
        bus.req_bridgeaddr       = 32'd0;
        bus.req_length           = 32'd0;
        bus.target_dataslot_ack  = 1'b0;
        bus.target_dataslot_done = 1'b0;
        bus.target_dataslot_err  = 3'd0;
        repeat (3) @(negedge clk);
        chk("rst_strobes",
            {bus.target_dataslot_write, bus.target_dataslot_read}, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_rsp", {bus.rsp_valid, bus.rsp_timeout, bus.rsp_err}, 0);
        chk("rst_id", {16'd0, bus.target_dataslot_id}, 0);
        chk("rst_len", bus.target_dataslot_length, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", bus.req_ready, 1);

        for (int i = 0; i < 4; i++) run_vec(i, vecs[i]);

        // Stale done held high across request issue and STROBE
        bus.target_dataslot_done = 1'b1;
        bus.target_dataslot_err  = 3'b011;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("stale_strobe", bus.target_dataslot_write, 1);
        repeat (3) begin
            @(negedge clk);
            chk("stale_no_rsp", bus.rsp_valid, 0);
            chk("stale_strobe_hold", bus.target_dataslot_write, 1);
        end
        bus.target_dataslot_ack = 1'b1;
        @(negedge clk);
        bus.target_dataslot_ack = 1'b0;
        chk("stale_ack_only", bus.rsp_valid, 0);
        chk("stale_strobe_low", bus.target_dataslot_write, 0);
        @(negedge clk);
        bus.target_dataslot_done = 1'b0;
        bus.target_dataslot_err  = 3'd0;
        chk("stale_rsp", bus.rsp_valid, 1);
        chk("stale_err", bus.rsp_err, 3'b011);
        wait_ready("stale", GAP);

        // Back-to-back with req_valid held and a fast handler
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.target_dataslot_done = 1'b1;
        first = -1;
        second = -1;
        nrsp = 0;
        nrdy = 0;
        s_prev = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            s = bus.target_dataslot_read | bus.target_dataslot_write;
            if (s && !s_prev) begin
                if (first < 0) begin
                    first = c;
                end else if (second < 0) begin
                    second = c;
                    bus.req_valid = 1'b0;
                end
            end
            if (bus.rsp_valid) nrsp++;
            if (first >= 0 && second < 0 && c > first && bus.req_ready) nrdy++;
            bus.target_dataslot_ack = s;
            s_prev = s;
        end
        bus.target_dataslot_done = 1'b0;
        bus.target_dataslot_ack  = 1'b0;
        chk("b2b_spacing", second - first, 3 + GAP);
        chk("b2b_low_min", (second - first - 1) >= GAP, 1);
        chk("b2b_ready_cycles", nrdy, 1);
        chk("b2b_rsp_count", nrsp, 2);
        chk("b2b_idle", bus.req_ready, 1);

        // Reset pulsed during WAIT_DONE
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_id    = 16'h55;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.target_dataslot_ack = 1'b1;
        @(negedge clk);
        bus.target_dataslot_ack = 1'b0;
        chk("rstmid_in_wait", bus.busy, 1);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rstmid_strobe", bus.target_dataslot_write, 0);
        chk("rstmid_busy", bus.busy, 0);
        chk("rstmid_rsp", bus.rsp_valid, 0);
        chk("rstmid_id", {16'd0, bus.target_dataslot_id}, 0);
        reset_n = 1'b1;
        bus.target_dataslot_done = 1'b1;
        @(negedge clk);
        chk("rstmid_ready", bus.req_ready, 1);
        chk("rstmid_busy2", bus.busy, 0);
        repeat (3) begin
            @(negedge clk);
            chk("rstmid_no_rsp", bus.rsp_valid, 0);
        end
        bus.target_dataslot_done = 1'b0;

`ifdef DATASLOT_CMD_TIMEOUT_EN
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("tmo_strobe", bus.target_dataslot_read, 1);
        n = 0;
        while (!bus.rsp_valid && n < 3 * TMO) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_cycles", n, TMO);
        chk("tmo_flag", bus.rsp_timeout, 1);
        chk("tmo_err", bus.rsp_err, 3'b111);
        chk("tmo_strobe_low", bus.target_dataslot_read, 0);
        wait_ready("tmo", GAP);
`else
        n = 0;
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
